// File: rtl/leaf_out_arbiter_pkg.sv
// Shared types and helpers for the leaf output arbiter and its output register.
package leaf_out_arbiter_pkg;

  localparam int DEF_PAYLOAD_BITS = 32;
  localparam int MAX_REQ          = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // Round-robin pick: first set bit strictly after gid, wrapping modulo num_req.
  // Falls back to gid when nothing is requesting.
  function automatic logic [2:0] next_grant(input logic [MAX_REQ-1:0] vld,
                                            input logic [2:0]         gid,
                                            input int                 num_req);
    logic [2:0] sel;
    int         idx;
    sel = gid;
    for (int i = MAX_REQ; i >= 1; i--) begin
      if (i <= num_req) begin
        idx = (int'(gid) + i) % num_req;
        if (vld[idx[2:0]]) sel = idx[2:0];
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/leaf_out_reg.sv
// Single-entry output register for a leaf_interface user port (ap_vld/ap_ack).
module leaf_out_reg
  import leaf_out_arbiter_pkg::*;
#(
  parameter int PAYLOAD_BITS = DEF_PAYLOAD_BITS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [PAYLOAD_BITS-1:0] din,
  input  logic                    ack_out,
  output logic [PAYLOAD_BITS-1:0] dout,
  output logic                    vld_out,
  output logic                    out_free
);

  // Free when empty or when the held word leaves on this edge.
  assign out_free = !vld_out || ack_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_out <= 1'b0;
      dout    <= '0;
    end else if (load) begin
      vld_out <= 1'b1;
      dout    <= din;
    end else if (ack_out && vld_out) begin
      vld_out <= 1'b0;
    end
  end

endmodule

// File: rtl/leaf_out_arbiter.sv
// Burst-granting round-robin arbiter merging NUM_REQ user streams onto one
// leaf_interface output port.
module leaf_out_arbiter
  import leaf_out_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int REQ_BITS     = 1,
  parameter int PAYLOAD_BITS = DEF_PAYLOAD_BITS,
  parameter int MAX_BURST    = 16,
  parameter int CNT_BITS     = 5
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ*PAYLOAD_BITS-1:0] din_req,
  input  logic [NUM_REQ-1:0]              vld_req,
  output logic [NUM_REQ-1:0]              ack_req,
  output logic [PAYLOAD_BITS-1:0]         dout,
  output logic                            vld_out,
  input  logic                            ack_out,
  output logic [REQ_BITS-1:0]             grant_id,
  output logic                            busy
);

  state_e                  state, state_nxt;
  logic [REQ_BITS-1:0]     gid_nxt;
  logic [CNT_BITS-1:0]     burst_cnt, cnt_nxt;
  logic                    out_free;
  logic                    xfer;
  logic                    last_word;
  logic [MAX_REQ-1:0]      vld_ext;
  logic [PAYLOAD_BITS-1:0] words [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_words
    assign words[i] = din_req[i*PAYLOAD_BITS +: PAYLOAD_BITS];
  end

  assign vld_ext   = MAX_REQ'(vld_req);
  assign busy      = (state == ST_GRANT);
  assign xfer      = |(ack_req & vld_req);
  assign last_word = (burst_cnt == CNT_BITS'(MAX_BURST - 1));

  // Reset gates the ack so no requester word is consumed in a reset cycle.
  always_comb begin
    ack_req = '0;
    if (busy && out_free && !reset) ack_req[grant_id] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    gid_nxt   = grant_id;
    cnt_nxt   = burst_cnt;
    case (state)
      ST_IDLE: begin
        if (|vld_req) begin
          gid_nxt   = REQ_BITS'(next_grant(vld_ext, 3'(grant_id), NUM_REQ));
          cnt_nxt   = '0;
          state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (xfer) begin
          cnt_nxt = burst_cnt + CNT_BITS'(1);
          if (last_word) state_nxt = ST_IDLE;
        end else if (out_free && !vld_req[grant_id]) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // grant_id resets to the last index so requester 0 wins the first search.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      grant_id  <= REQ_BITS'(NUM_REQ - 1);
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      grant_id  <= gid_nxt;
      burst_cnt <= cnt_nxt;
    end
  end

  leaf_out_reg #(
    .PAYLOAD_BITS(PAYLOAD_BITS)
  ) u_out_reg (
    .clk     (clk),
    .reset   (reset),
    .load    (xfer),
    .din     (words[grant_id]),
    .ack_out (ack_out),
    .dout    (dout),
    .vld_out (vld_out),
    .out_free(out_free)
  );

endmodule

// File: doc/leaf_out_arbiter.md
Name: leaf_out_arbiter

Overview:
- Round-robin arbiter that lets NUM_REQ user output streams share one leaf_interface output port (din_leaf_user2interface / vld_user2interface / ack_interface2user).
- Sits between several HLS operator output streams (ap_vld/ap_ack style) and the single interface input of a leaf.
- Grants whole bursts of up to MAX_BURST words so streams are not interleaved word-by-word.
- The output is registered once and exposes the granted source index.

Parameters:
- NUM_REQ, 2, number of requesting user streams (2..8).
- REQ_BITS, 1, width of grant index; must equal clog2(NUM_REQ), minimum 1.
- PAYLOAD_BITS, 32, data width per word.
- MAX_BURST, 16, maximum words per grant; must be at least 1.
- CNT_BITS, 5, burst counter width; must be at least clog2(MAX_BURST+1).

Ports:
- clk  input  1  single clock.
- reset  input  1  synchronous, active-high reset.
- din_req  input  NUM_REQ*PAYLOAD_BITS  requester data; requester i occupies bits [i*PAYLOAD_BITS +: PAYLOAD_BITS].
- vld_req  input  NUM_REQ  requester valid, one bit per requester.
- ack_req  output  NUM_REQ  acknowledge to each requester.
- dout  output  PAYLOAD_BITS  data to the leaf_interface user port.
- vld_out  output  1  output valid.
- ack_out  input  1  leaf_interface acknowledge.
- grant_id  output  REQ_BITS  index of the current or last granted requester.
- busy  output  1  high while the state is GRANT.

Behaviour:
- Transfer rule: a word moves on any rising edge where valid and ack are both high on that link, for both requester links and the output link.
- Reset (synchronous, priority over everything):
  - state=IDLE, vld_out=0, dout=0, ack_req=0, grant_id=NUM_REQ-1 (so requester 0 wins first), burst_cnt=0, busy=0.
  - Reset asserted mid-burst drops any held output word. A requester's in-flight word is not acked in that cycle.
- Output register:
  - Single entry, out_free = !vld_out || ack_out.
  - When a requester transfer occurs: dout <= that word, vld_out <= 1.
  - Else if ack_out && vld_out: vld_out <= 0. dout holds its value.
  - While vld_out && !ack_out, dout and vld_out must remain stable.
  - Latency from requester transfer to vld_out is 1 cycle. Full throughput of 1 word/cycle is sustained while ack_out stays high.
- ack_req:
  - Combinational: ack_req[i] = (state==GRANT) && (grant_id==i) && out_free.
  - All other bits are 0. At most one bit is high.
- FSM, two states:
  - IDLE:
    - busy=0.
    - If any vld_req bit is high, select the first set bit searching from grant_id+1 upward, wrapping modulo NUM_REQ. Set grant_id to it, burst_cnt<=0, and go to GRANT.
    - Otherwise stay. Arbitration costs 1 bubble cycle.
  - GRANT:
    - On each requester transfer, burst_cnt<=burst_cnt+1.
    - Release to IDLE when the transfer completing the MAX_BURST-th word occurs.
    - Also release when out_free=1 and vld_req[grant_id]=0, i.e. the requester idles while it could send.
    - While out_free=0 the grant is held regardless of vld_req.
    - grant_id keeps its value in IDLE; it serves as the round-robin pointer.
- Simultaneous events: a final-word transfer and an ack_out in the same cycle load the new word (vld_out stays 1).
- Requesters not granted see ack_req=0 and must hold their data (standard ap_hs).
- No data reordering: words from one requester leave in arrival order.
- Bursts never interleave.

Decomposition:
- Shared package holds:
  - localparams for FSM state encoding (ST_IDLE, ST_GRANT);
  - the round-robin search function (next_grant(vld_req, grant_id));
  - default PAYLOAD_BITS=32.
- One sub-module: leaf_out_reg, the single-entry output register with out_free logic, reusable at other leaf_interface user ports.
- The FSM, counter and ack generation stay in leaf_out_arbiter.

Test Plan:
- Single stream: NUM_REQ=2, MAX_BURST=4. Req0 streams 0x10..0x17 continuously, ack_out=1.
  - Required: dout 0x10..0x13, then a 1-cycle bubble, then 0x14..0x17.
  - grant_id stays 0; vld_out first rises 2 cycles after vld_req[0].
- Fairness: both requesters always valid, MAX_BURST=4.
  - Required: output order 4 words from req0, 4 from req1, 4 from req0.
  - grant_id toggles 0,1,0; no word is lost or duplicated (scoreboard per source).
- Backpressure: ack_out low for 5 cycles mid-burst.
  - Required: dout/vld_out stable, ack_req all 0 during the stall, burst_cnt unchanged.
  - Streaming resumes the cycle after ack_out rises.
- Early release: req1 sends 2 words then drops vld with MAX_BURST=16.
  - Required: busy falls, and req0, valid and waiting, is granted after 1 IDLE cycle.
- Reset mid-burst: assert reset for 1 cycle after 2 of 4 words.
  - Required: next cycle vld_out=0, ack_req=0, state IDLE, grant_id=NUM_REQ-1.
  - Req0 wins the next arbitration.
- Random: 3 requesters, random vld gaps and random ack_out, 10k cycles.
  - Required: per-source order preserved, bursts ≤ MAX_BURST, never more than one ack_req high.
